fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage that sits directly downstream of the PC register.
//  - Takes the current PC, issues one request at a time to instruction memory
//    (variable latency) and loads the returned word into the IF/ID register.
//  - Tells the next-PC mux when the PC may advance.
//  - Handles hazard-unit stalls and branch/jump flushes, including a response
//    that arrives while stalled or after a flush.
// PARAMETERS
//  LEN      32  PC / address width
//  INSTR_W  32  instruction word width
//  PC_STEP  4   increment applied to the PC for o_pc_plus4
// PORTS
//  i_clk          in   1        clock; all state updates on rising edge
//  i_rst          in   1        asynchronous reset, active-low
//  i_pc           in   LEN      current PC from the PC register
//  i_stall        in   1        hazard unit: hold IF/ID, issue no new fetch
//  i_flush        in   1        branch/jump redirect: squash fetch and IF/ID
//  o_imem_req     out  1        one-cycle fetch request (memory always accepts)
//  o_imem_addr    out  LEN      fetch address, valid while o_imem_req=1
//  i_imem_rvalid  in   1        response strobe, >=1 cycle after the request
//  i_imem_rdata   in   INSTR_W  instruction word, valid with i_imem_rvalid
//  o_pc_hold      out  1        1: next-PC mux feeds back i_pc (i_flush wins)
//  o_valid        out  1        IF/ID holds a real instruction
//  o_instr        out  INSTR_W  IF/ID instruction
//  o_pc_plus4     out  LEN      IF/ID: fetch address + PC_STEP, modulo 2^LEN
// BEHAVIOUR
//  Reset (async, i_rst=0)
//   - State=IDLE.
//   - o_valid, o_instr, o_pc_plus4, internal buffers all cleared to 0.
//   - Takes effect immediately, with no clock edge.
//  Combinational outputs
//   - o_imem_req = (IDLE & !i_stall & !i_flush); o_imem_addr = i_pc.
//   - o_pc_hold = 0 only in the "load" cases below, otherwise 1.
//  FSM (one outstanding request maximum)
//   - IDLE: if req is issued, capture i_pc+PC_STEP into pend_pc4 -> WAIT.
//     i_imem_rvalid is ignored here (spurious).
//   - WAIT, rvalid=0:
//     - i_flush -> DROP.
//     - else stay in WAIT.
//   - WAIT, rvalid=1:
//     - i_flush -> discard the word -> IDLE.
//     - i_stall -> capture the word into the skid buffer -> HOLD.
//     - else load IF/ID (o_valid=1, o_instr=rdata, o_pc_plus4=pend_pc4),
//       o_pc_hold=0 this cycle -> IDLE.
//   - HOLD:
//     - i_flush -> drop the buffer -> IDLE.
//     - !i_stall -> load IF/ID from the buffer, o_pc_hold=0 -> IDLE.
//     - else stay in HOLD.
//   - DROP: wait for rvalid, discard it -> IDLE. i_flush is ignored here.
//  IF/ID register rules, in priority order
//   - i_flush: o_valid <= 0 (o_instr and o_pc_plus4 unchanged); flush beats stall.
//   - i_stall: IF/ID holds its contents.
//   - load case: IF/ID is written as above.
//   - otherwise: o_valid <= 0 (bubble).
//  Timing
//   - Minimum latency: request in cycle N, rvalid in N+1, o_valid=1 after edge N+1.
//   - Peak throughput: 1 instruction per 2 cycles.
//  Boundary cases
//   - o_pc_plus4 wraps 0xFFFFFFFC -> 0x00000000.
//   - Reset mid-WAIT or mid-DROP abandons the request. The memory is reset on
//     the same i_rst and must not deliver a stale rvalid.
// TESTING
//  1. Latency 1, no stall: i_pc=0x100, rdata=0x20080005 ->
//     req/addr=0x100 in cycle 0; after edge 1: o_valid=1, o_instr=0x20080005,
//     o_pc_plus4=0x104; o_pc_hold=0 for exactly 1 cycle.
//  2. i_stall=1 when rvalid arrives (word 0x8C090004) -> HOLD, IF/ID unchanged,
//     o_pc_hold=1; drop stall after 3 cycles -> next edge o_instr=0x8C090004.
//  3. Latency 3, i_flush in the cycle after req -> DROP; rvalid in cycle 3 is
//     discarded, o_valid=0; next req in cycle 4 with addr = new i_pc.
//  4. HOLD with i_stall=1 and i_flush=1 together -> buffer dropped, o_valid=0,
//     state IDLE; next req in the following cycle.
//  5. i_rst=0 asserted mid-WAIT (no clock edge) -> o_valid=0, o_instr=0 at once;
//     after release, the first req goes out in the first cycle with addr=i_pc.
//  6. rvalid pulsed in IDLE while i_stall=1 -> ignored, IF/ID and o_valid unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage directly downstream of the PC register.
//
// The stage takes the current PC and sends it to instruction memory. Only one
// request can be in flight at a time, and memory latency is variable. The
// returned word is loaded into the IF/ID register. The stage also tells the
// next-PC mux when the PC may advance. It absorbs hazard stalls and
// branch/jump flushes, including a response that arrives while the pipeline
// is stalled or after a flush.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active-low
//   i_pc           current PC from the PC register
//   i_stall        hazard unit: hold IF/ID, issue no new fetch
//   i_flush        branch/jump redirect: squash outstanding fetch and IF/ID
//   o_imem_req     one-cycle fetch request (memory always accepts)
//   o_imem_addr    fetch address, meaningful while o_imem_req=1
//   i_imem_rvalid  response strobe, at least one cycle after the request
//   i_imem_rdata   instruction word, valid with i_imem_rvalid
//   o_pc_hold      1: next-PC mux recirculates i_pc; 0 only when IF/ID loads
//   o_valid        IF/ID holds a real instruction
//   o_instr        IF/ID instruction
//   o_pc_plus4     IF/ID fetch address + PC_STEP (wraps modulo 2^LEN)
module fetch_unit #(
    parameter int LEN     = 32,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [LEN-1:0]     i_pc,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_imem_req,
    output logic [LEN-1:0]     o_imem_addr,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_pc_hold,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [LEN-1:0]     o_pc_plus4
);

    // IDLE: free to fetch. WAIT: request outstanding.
    // HOLD: word parked in the skid buffer during a stall.
    // DROP: request squashed, response still to be swallowed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [LEN-1:0]       pend_pc4_r;
    logic [INSTR_W-1:0]   skid_r;
    logic                 valid_r;
    logic [INSTR_W-1:0]   instr_r;
    logic [LEN-1:0]       pc_plus4_r;

    logic                 req_s;
    logic                 load_s;
    logic                 capture_s;
    logic [INSTR_W-1:0]   load_instr_s;

    // Next-state decode plus request/load/skid-capture strobes
    always_comb begin
        state_nxt_s  = state_r;
        req_s        = 1'b0;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        load_instr_s = i_imem_rdata;
        case (state_r)
            IDLE: begin
                // A response strobe here is spurious and deliberately ignored
                if (!i_stall && !i_flush) begin
                    req_s       = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!i_imem_rvalid) begin
                    if (i_flush) begin
                        state_nxt_s = DROP;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else if (i_flush) begin
                    state_nxt_s = IDLE;
                end else if (i_stall) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    load_s      = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                load_instr_s = skid_r;
                if (i_flush) begin
                    state_nxt_s = IDLE;
                end else if (!i_stall) begin
                    load_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DROP: begin
                // Flush is irrelevant here: the word is already doomed
                if (i_imem_rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch address + step of the outstanding request; it stays valid through HOLD
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend_pc4_r <= {LEN{1'b0}};
        end else if (req_s) begin
            pend_pc4_r <= i_pc + LEN'(PC_STEP);
        end else begin
            pend_pc4_r <= pend_pc4_r;
        end
    end

    // Skid buffer for a word that arrives while the pipeline is stalled
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            skid_r <= {INSTR_W{1'b0}};
        end else if (capture_s) begin
            skid_r <= i_imem_rdata;
        end else begin
            skid_r <= skid_r;
        end
    end

    // IF/ID register: flush beats stall, stall beats load, else a bubble
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_r    <= 1'b0;
            instr_r    <= {INSTR_W{1'b0}};
            pc_plus4_r <= {LEN{1'b0}};
        end else if (i_flush) begin
            valid_r    <= 1'b0;
        end else if (i_stall) begin
            valid_r    <= valid_r;
        end else if (load_s) begin
            valid_r    <= 1'b1;
            instr_r    <= load_instr_s;
            pc_plus4_r <= pend_pc4_r;
        end else begin
            valid_r    <= 1'b0;
        end
    end

    assign o_imem_req  = req_s;
    assign o_imem_addr = i_pc;
    assign o_pc_hold   = ~load_s;
    assign o_valid     = valid_r;
    assign o_instr     = instr_r;
    assign o_pc_plus4  = pc_plus4_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized, self-checking bench for fetch_unit.
//
// The driver drives one cycle at a time. A transaction-level model follows
// each fetch: its address, its word, its arrival and whether a flush has
// doomed it. The model predicts the request, the PC hold and the IF/ID
// contents. Each delivered fetch goes into a scoreboard queue. A separate
// monitor pops that queue whenever o_valid rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        rvalid;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        pc_hold;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    fetch_unit #(.LEN(32), .INSTR_W(32), .PC_STEP(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc          (pc),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_pc_hold     (pc_hold),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc_plus4    (pc_plus4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb_q[$];

    // Model of the single in-flight fetch
    bit          m_out;    // a fetch is in flight (issued, not yet delivered or discarded)
    bit          m_arr;    // its word has come back and waits for the stall to end
    bit          m_fl;     // a flush hit it before its word came back
    logic [31:0] m_addr;
    logic [31:0] m_word;
    // Model of the IF/ID register as seen after the last edge
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    // Memory: fixed latency per request
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs at the negedge, advance the model
    task automatic cycle(input bit s, input bit f, input logic [31:0] p,
                         input int lat, input logic [31:0] w, input bit spur);
        bit dlv;
        bit exp_req;
        @(posedge clk);
        #1;
        stall  = s;
        flush  = f;
        pc     = p;
        rvalid = 1'b0;
        rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rvalid   = 1'b1;
                rdata    = mem_word;
                mem_busy = 1'b0;
            end
        end else if (spur && !m_out) begin
            rvalid = 1'b1;
        end
        @(negedge clk);
        check("if_valid", valid, m_valid);
        check("if_instr", instr, m_instr);
        check("if_pc4", pc_plus4, m_pc4);
        exp_req = !m_out && !s && !f;
        dlv     = 1'b0;
        if (m_out) begin
            if (!m_arr) begin
                if (rvalid) begin
                    if (m_fl || f) begin
                        m_out = 1'b0;
                    end else if (s) begin
                        m_arr = 1'b1;
                    end else begin
                        dlv   = 1'b1;
                        m_out = 1'b0;
                    end
                end else if (f) begin
                    m_fl = 1'b1;
                end
            end else begin
                if (f) begin
                    m_out = 1'b0;
                end else if (!s) begin
                    dlv   = 1'b1;
                    m_out = 1'b0;
                end
            end
        end
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, p);
        check("pc_hold", pc_hold, !dlv);
        if (dlv) begin
            sb_q.push_back({m_word, m_addr + 32'd4});
            m_valid = 1'b1;
            m_instr = m_word;
            m_pc4   = m_addr + 32'd4;
        end else if (f || !s) begin
            m_valid = 1'b0;
        end
        if (exp_req) begin
            m_out    = 1'b1;
            m_arr    = 1'b0;
            m_fl     = 1'b0;
            m_addr   = p;
            m_word   = w;
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_word = w;
        end
    endtask

    // Flush until any in-flight or dropped fetch has been resolved
    task automatic settle();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, $urandom, 1, $urandom, 1'b0);
    endtask

    // Scoreboard monitor: each rise of o_valid is one delivered instruction
    initial begin
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && valid && !prev_v) begin
                check("sb_has_entry", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_instr", instr, e.instr);
                    check("sb_pc4", pc_plus4, e.pc4);
                end
            end
            prev_v = valid;
        end
    end

    initial begin
        rst = 1'b0; stall = 1'b1; flush = 1'b0; pc = 32'h0; rvalid = 1'b0; rdata = 32'h0;
        m_out = 1'b0; m_arr = 1'b0; m_fl = 1'b0; m_addr = 32'h0; m_word = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_word = 32'h0;
        #3;
        check("rst_valid", valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", pc_plus4, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Latency 1, no stall
        cycle(1'b0, 1'b0, 32'h100, 1, 32'h20080005, 1'b0);
        cycle(1'b0, 1'b0, 32'h100, 1, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h104, 1, 32'h0, 1'b0);
        check("t1_instr", instr, 32'h20080005);
        check("t1_pc4", pc_plus4, 32'h104);
        settle();

        // Word arrives under stall, released after three stalled cycles
        cycle(1'b0, 1'b0, 32'h300, 1, 32'h8C090004, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h304, 1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h304, 1, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h304, 1, 32'h0, 1'b0);
        check("t2_instr", instr, 32'h8C090004);
        settle();

        // Latency 3 with a flush right after the request, then a new fetch
        cycle(1'b0, 1'b0, 32'h400, 3, 32'hDEAD0001, 1'b0);
        cycle(1'b0, 1'b1, 32'h400, 1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h400, 1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h400, 1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h500, 1, 32'h11112222, 1'b0);
        settle();

        // HOLD with stall and flush together
        cycle(1'b0, 1'b0, 32'h600, 1, 32'hCAFE0600, 1'b0);
        cycle(1'b1, 1'b0, 32'h604, 1, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h604, 1, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h700, 2, 32'hCAFE0700, 1'b0);
        settle();

        // PC+4 wrap at the top of the address space
        cycle(1'b0, 1'b0, 32'hFFFFFFFC, 1, 32'h0BADF00D, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        check("wrap_pc4", pc_plus4, 32'h0);

        // Spurious response in IDLE under stall is ignored
        cycle(1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        check("spur_valid", valid, 1'b1);

        // Asynchronous reset mid-WAIT
        cycle(1'b0, 1'b0, 32'h800, 4, 32'h12345678, 1'b0);
        #2 rst = 1'b0;
        stall = 1'b1; flush = 1'b0; rvalid = 1'b0;
        #1;
        check("arst_valid", valid, 1'b0);
        check("arst_instr", instr, 32'h0);
        check("arst_pc4", pc_plus4, 32'h0);
        m_out = 1'b0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; mem_busy = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h900, 1, 32'h9ABCDEF0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, p,
                  $urandom_range(1, 4), $urandom, $urandom_range(0, 7) == 0);
        end
        settle();
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
